// File: rtl/switch_debouncer_pkg.sv
// Shared definitions for the switch debouncer: channel FSM states and sizing constants.
package switch_debouncer_pkg;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_SETTLING = 1'b1
    } state_t;

    localparam int unsigned SYNC_STAGES         = 2;
    localparam int unsigned MIN_DEBOUNCE_CYCLES = 2;

endpackage

// File: rtl/switch_debouncer_ch.sv
// Single switch channel: two-flop synchroniser, settle FSM with counter, optional edge pulses.
// Edge pulses are built only when SWITCH_DEBOUNCER_EDGE_EN is defined; otherwise tied low.
module switch_debouncer_ch
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_in,
    output logic sw_out,
    output logic sw_rise,
    output logic sw_fall,
    output logic sw_busy
);

    localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   s2;
    state_t                 state, state_nxt;
    logic [CNT_W-1:0]       cnt, cnt_nxt;
    logic                   out_nxt;

    assign s2 = sync[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) sync <= '0;
        else     sync <= {sync[SYNC_STAGES-2:0], sw_in};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_STABLE;
            cnt    <= '0;
            sw_out <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            sw_out <= out_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        out_nxt   = sw_out;
        unique case (state)
            ST_STABLE: begin
                if (s2 != sw_out) begin
                    state_nxt = ST_SETTLING;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            ST_SETTLING: begin
                if (s2 == sw_out) begin
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    // The input held long enough: commit the new level.
                    out_nxt   = s2;
                    state_nxt = ST_STABLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt   = cnt + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        sw_busy = (state == ST_SETTLING);
    end

`ifdef SWITCH_DEBOUNCER_EDGE_EN
    // Pulses are registered alongside sw_out so they coincide with its change.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_rise <= 1'b0;
            sw_fall <= 1'b0;
        end else begin
            sw_rise <= out_nxt & ~sw_out;
            sw_fall <= ~out_nxt & sw_out;
        end
    end
`else
    assign sw_rise = 1'b0;
    assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debouncer.sv
// N_SW independent debounced switch channels between the switch pads and the gate logic.
// Define SWITCH_DEBOUNCER_EDGE_EN to enable the sw_rise/sw_fall pulse outputs.
module switch_debouncer
    import switch_debouncer_pkg::*;
#(
    parameter int unsigned N_SW            = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_SW-1:0] sw_in,
    output logic [N_SW-1:0] sw_out,
    output logic [N_SW-1:0] sw_rise,
    output logic [N_SW-1:0] sw_fall,
    output logic [N_SW-1:0] sw_busy
);

    if (DEBOUNCE_CYCLES < MIN_DEBOUNCE_CYCLES) begin : g_bad_cycles
        $error("switch_debouncer: DEBOUNCE_CYCLES must be at least %0d", MIN_DEBOUNCE_CYCLES);
    end
    if (N_SW < 1) begin : g_bad_width
        $error("switch_debouncer: N_SW must be at least 1");
    end

    for (genvar i = 0; i < N_SW; i++) begin : g_ch
        switch_debouncer_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .sw_in  (sw_in[i]),
            .sw_out (sw_out[i]),
            .sw_rise(sw_rise[i]),
            .sw_fall(sw_fall[i]),
            .sw_busy(sw_busy[i])
        );
    end

endmodule
